// File: rtl/debug_trace_pkg.sv
// Shared definitions for the debug trace buffer: capture states, mode
// encodings and the width of one stored trace entry.
package debug_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_CIRC = 1'b1;

    function automatic int entry_width(input int ch_w, input int tag_w, input int data_w);
        return ch_w + tag_w + data_w;
    endfunction

endpackage

// File: rtl/trace_mem.sv
// Simple dual-port trace RAM: one write port and one registered read port.
// There is no reset, so the array maps onto block RAM.
module trace_mem #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Read-before-write: a read of the address being written returns old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/debug_trace_buffer.sv
// Multi-channel trace capture: arbitrates event channels into a circular
// buffer with fill-and-stop or trigger-plus-post-count capture.
module debug_trace_buffer #(
    parameter int CH     = 2,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 mode,
    input  logic [CH_W-1:0]      trig_ch,
    input  logic [TAG_W-1:0]     trig_tag,
    input  logic [PTR_W-1:0]     post_count,
    input  logic [CH-1:0]        ch_valid,
    input  logic [CH*TAG_W-1:0]  ch_tag,
    input  logic [CH*DATA_W-1:0] ch_data,
    input  logic                 rd_en,
    input  logic [PTR_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [CH_W-1:0]      rd_ch,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 busy,
    output logic                 done,
    output logic [PTR_W:0]       count,
    output logic [15:0]          dropped
);

    import debug_trace_pkg::*;

    localparam int             ENTRY_W = entry_width(CH_W, TAG_W, DATA_W);
    localparam logic [PTR_W:0] FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] LAST    = (PTR_W+1)'(DEPTH - 1);

    trace_state_t       state_q, state_d;
    logic               mode_q;
    logic [CH_W-1:0]    trig_ch_q;
    logic [TAG_W-1:0]   trig_tag_q;
    logic [PTR_W-1:0]   post_q, remaining_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W:0]     count_q;
    logic [15:0]        dropped_q;
    logic               rd_valid_q;

    logic [CH_W-1:0]    win_ch;
    logic [TAG_W-1:0]   win_tag;
    logic [DATA_W-1:0]  win_data;
    logic               any_valid;
    logic [3:0]         n_valid;
    logic               capture, trig_hit;
    logic [16:0]        drop_sum;

    logic [PTR_W-1:0]   oldest, rd_addr;
    logic               rd_hit;
    logic [ENTRY_W-1:0] mem_rdata;
    logic [CH_W-1:0]    mem_ch;
    logic [TAG_W-1:0]   mem_tag;
    logic [DATA_W-1:0]  mem_data;

    // Fixed-priority arbiter: scanning downward leaves the lowest valid channel as winner.
    always_comb begin
        win_ch    = '0;
        win_tag   = '0;
        win_data  = '0;
        any_valid = 1'b0;
        n_valid   = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (ch_valid[i]) begin
                win_ch    = CH_W'(i);
                win_tag   = ch_tag[i*TAG_W +: TAG_W];
                win_data  = ch_data[i*DATA_W +: DATA_W];
                any_valid = 1'b1;
                n_valid   = n_valid + 4'd1;
            end
        end
    end

    assign busy     = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign done     = (state_q == ST_DONE);
    assign capture  = busy && any_valid && !arm;
    assign trig_hit = (win_ch == trig_ch_q) && (win_tag == trig_tag_q);
    assign drop_sum = {1'b0, dropped_q} + 17'(n_valid - 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (capture) begin
                        if (mode_q == MODE_FILL) begin
                            if (count_q == LAST) begin
                                state_d = ST_DONE;
                            end
                        end else if (trig_hit) begin
                            state_d = (post_q == '0) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (capture && (remaining_q == PTR_W'(1))) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pointers, counters and the configuration latched on arm.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= MODE_FILL;
            trig_ch_q   <= '0;
            trig_tag_q  <= '0;
            post_q      <= '0;
            remaining_q <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            dropped_q   <= '0;
        end else if (arm) begin
            mode_q      <= mode;
            trig_ch_q   <= trig_ch;
            trig_tag_q  <= trig_tag;
            post_q      <= post_count;
            remaining_q <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            dropped_q   <= '0;
        end else if (capture) begin
            wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
            dropped_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (count_q != FULL) begin
                count_q <= count_q + (PTR_W+1)'(1);
            end
            if (state_q == ST_ARMED) begin
                remaining_q <= post_q;
            end else begin
                remaining_q <= remaining_q - PTR_W'(1);
            end
        end
    end

    // Once the buffer has wrapped, the oldest entry sits at the write pointer.
    assign oldest  = (count_q == FULL) ? wr_ptr_q : '0;
    assign rd_addr = oldest + rd_idx;
    assign rd_hit  = rd_en && ({1'b0, rd_idx} < count_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_hit;
        end
    end

    trace_mem #(
        .ADDR_W (PTR_W),
        .WIDTH  (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (capture),
        .waddr (wr_ptr_q),
        .wdata ({win_ch, win_tag, win_data}),
        .re    (rd_hit),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

    assign {mem_ch, mem_tag, mem_data} = mem_rdata;

    // The RAM has no reset, so read data is masked until a valid read returns.
    assign rd_valid = rd_valid_q;
    assign rd_ch    = rd_valid_q ? mem_ch   : '0;
    assign rd_tag   = rd_valid_q ? mem_tag  : '0;
    assign rd_data  = rd_valid_q ? mem_data : '0;
    assign count    = count_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Self-checking bench for debug_trace_buffer: table vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_debug_trace_buffer;

    localparam int CH     = 2;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;
    localparam int CH_W   = 1;

    localparam int S_IDLE  = 0;
    localparam int S_ARMED = 1;
    localparam int S_POST  = 2;
    localparam int S_DONE  = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 arm;
    logic                 mode;
    logic [CH_W-1:0]      trig_ch;
    logic [TAG_W-1:0]     trig_tag;
    logic [PTR_W-1:0]     post_count;
    logic [CH-1:0]        ch_valid;
    logic [CH*TAG_W-1:0]  ch_tag;
    logic [CH*DATA_W-1:0] ch_data;
    logic                 rd_en;
    logic [PTR_W-1:0]     rd_idx;
    logic                 rd_valid;
    logic [CH_W-1:0]      rd_ch;
    logic [TAG_W-1:0]     rd_tag;
    logic [DATA_W-1:0]    rd_data;
    logic                 busy;
    logic                 done;
    logic [PTR_W:0]       count;
    logic [15:0]          dropped;

    debug_trace_buffer #(
        .CH     (CH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .mode       (mode),
        .trig_ch    (trig_ch),
        .trig_tag   (trig_tag),
        .post_count (post_count),
        .ch_valid   (ch_valid),
        .ch_tag     (ch_tag),
        .ch_data    (ch_data),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_valid   (rd_valid),
        .rd_ch      (rd_ch),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: the buffer is an ordered queue, oldest entry first.
    typedef struct {
        int          ch;
        int          tag;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_state = S_IDLE;
    int          m_mode, m_tch, m_ttag, m_post, m_rem;
    int          m_dropped = 0;
    logic        exp_rv;
    int          exp_rch, exp_rtag;
    logic [31:0] exp_rdata;

    typedef struct {
        logic       a;
        logic       m;
        int         tch;
        int         ttag;
        int         post;
        logic [1:0] v;
        int         t0;
        int         t1;
        logic       re;
        int         ri;
        int         e_count;
        logic       e_busy;
        logic       e_done;
        int         e_dropped;
        logic       e_rv;
        int         e_rch;
        int         e_rtag;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] data_of(input int ch, input int tag);
        logic [31:0] c;
        c = cyc;
        return {c[23:0], 3'(ch), 5'(tag)};
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_state   = S_IDLE;
        m_dropped = 0;
        exp_rv    = 1'b0;
        exp_rch   = 0;
        exp_rtag  = 0;
        exp_rdata = '0;
    endfunction

    // Advances the model by one rising edge using the inputs currently driven.
    function automatic void model_step();
        int   n;
        int   w;
        ent_t e;
        exp_rv    = 1'b0;
        exp_rch   = 0;
        exp_rtag  = 0;
        exp_rdata = '0;
        if (rd_en && int'(rd_idx) < mq.size()) begin
            exp_rv    = 1'b1;
            exp_rch   = mq[rd_idx].ch;
            exp_rtag  = mq[rd_idx].tag;
            exp_rdata = mq[rd_idx].data;
        end
        if (arm) begin
            mq.delete();
            m_dropped = 0;
            m_mode    = int'(mode);
            m_tch     = int'(trig_ch);
            m_ttag    = int'(trig_tag);
            m_post    = int'(post_count);
            m_state   = S_ARMED;
            return;
        end
        if (m_state != S_ARMED && m_state != S_POST) return;
        n = 0;
        w = -1;
        for (int i = CH - 1; i >= 0; i--) begin
            if (ch_valid[i]) begin
                n++;
                w = i;
            end
        end
        if (n == 0) return;
        e.ch   = w;
        e.tag  = int'(ch_tag[w*TAG_W +: TAG_W]);
        e.data = ch_data[w*DATA_W +: DATA_W];
        m_dropped = m_dropped + n - 1;
        if (m_dropped > 65535) m_dropped = 65535;
        mq.push_back(e);
        if (mq.size() > DEPTH) void'(mq.pop_front());
        if (m_state == S_ARMED) begin
            if (m_mode == 0) begin
                if (mq.size() == DEPTH) m_state = S_DONE;
            end else if (e.ch == m_tch && e.tag == m_ttag) begin
                if (m_post == 0) begin
                    m_state = S_DONE;
                end else begin
                    m_state = S_POST;
                    m_rem   = m_post;
                end
            end
        end else begin
            m_rem--;
            if (m_rem == 0) m_state = S_DONE;
        end
    endfunction

    task automatic checkOutput();
        check("count",    64'(count),    64'(mq.size()));
        check("busy",     64'(busy),     64'(m_state == S_ARMED || m_state == S_POST));
        check("done",     64'(done),     64'(m_state == S_DONE));
        check("dropped",  64'(dropped),  64'(m_dropped));
        check("rd_valid", 64'(rd_valid), 64'(exp_rv));
        check("rd_ch",    64'(rd_ch),    64'(exp_rch));
        check("rd_tag",   64'(rd_tag),   64'(exp_rtag));
        check("rd_data",  64'(rd_data),  64'(exp_rdata));
    endtask

    task automatic applyStimulus(input logic a, input logic [1:0] v, input int t0, input int t1,
                                 input logic re, input int ri);
        arm      = a;
        ch_valid = v;
        ch_tag   = {5'(t1), 5'(t0)};
        ch_data  = {data_of(1, t1), data_of(0, t0)};
        rd_en    = re;
        rd_idx   = 4'(ri);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
    endtask

    task automatic configure(input logic m, input int tch, input int ttag, input int post);
        mode       = m;
        trig_ch    = 1'(tch);
        trig_tag   = 5'(ttag);
        post_count = 4'(post);
    endtask

    task automatic do_reset();
        arm      = 1'b0;
        ch_valid = '0;
        rd_en    = 1'b0;
        reset    = 1'b1;
        #2;
        model_reset();
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput();
    endtask

    task automatic read_tag(input int idx, input int tag, input string name);
        applyStimulus(1'b0, 2'b00, 0, 0, 1'b1, idx);
        check(name, 64'(rd_tag), 64'(tag));
    endtask

    initial begin
        configure(1'b0, 0, 0, 0);
        ch_tag  = '0;
        ch_data = '0;
        rd_idx  = '0;
        do_reset();
        check("reset_count", 64'(count), 64'd0);

        // Table: mode 0 with contention and reads, then a mode-1 trigger with post_count 0.
        tbl[0] = '{1'b1, 1'b0, 0, 0, 0, 2'b00, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 0};
        tbl[1] = '{1'b0, 1'b0, 0, 0, 0, 2'b11, 3, 4, 1'b0, 0, 1, 1'b1, 1'b0, 1, 1'b0, 0, 0};
        tbl[2] = '{1'b0, 1'b0, 0, 0, 0, 2'b10, 0, 9, 1'b0, 0, 2, 1'b1, 1'b0, 1, 1'b0, 0, 0};
        tbl[3] = '{1'b0, 1'b0, 0, 0, 0, 2'b00, 0, 0, 1'b1, 0, 2, 1'b1, 1'b0, 1, 1'b1, 0, 3};
        tbl[4] = '{1'b0, 1'b0, 0, 0, 0, 2'b00, 0, 0, 1'b1, 1, 2, 1'b1, 1'b0, 1, 1'b1, 1, 9};
        tbl[5] = '{1'b0, 1'b0, 0, 0, 0, 2'b00, 0, 0, 1'b1, 2, 2, 1'b1, 1'b0, 1, 1'b0, 0, 0};
        tbl[6] = '{1'b1, 1'b1, 1, 5, 0, 2'b11, 1, 2, 1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 0};
        tbl[7] = '{1'b0, 1'b1, 1, 5, 0, 2'b01, 5, 0, 1'b0, 0, 1, 1'b1, 1'b0, 0, 1'b0, 0, 0};
        tbl[8] = '{1'b0, 1'b1, 1, 5, 0, 2'b10, 0, 5, 1'b0, 0, 2, 1'b0, 1'b1, 0, 1'b0, 0, 0};
        tbl[9] = '{1'b0, 1'b1, 1, 5, 0, 2'b11, 6, 7, 1'b1, 1, 2, 1'b0, 1'b1, 0, 1'b1, 1, 5};
        for (int r = 0; r < 10; r++) begin
            configure(tbl[r].m, tbl[r].tch, tbl[r].ttag, tbl[r].post);
            applyStimulus(tbl[r].a, tbl[r].v, tbl[r].t0, tbl[r].t1, tbl[r].re, tbl[r].ri);
            check("tbl_count",    64'(count),    64'(tbl[r].e_count));
            check("tbl_busy",     64'(busy),     64'(tbl[r].e_busy));
            check("tbl_done",     64'(done),     64'(tbl[r].e_done));
            check("tbl_dropped",  64'(dropped),  64'(tbl[r].e_dropped));
            check("tbl_rd_valid", 64'(rd_valid), 64'(tbl[r].e_rv));
            check("tbl_rd_ch",    64'(rd_ch),    64'(tbl[r].e_rch));
            check("tbl_rd_tag",   64'(rd_tag),   64'(tbl[r].e_rtag));
        end

        // Fill-and-stop: ch0 for 20 cycles, only the first 16 are kept.
        configure(1'b0, 0, 0, 0);
        applyStimulus(1'b1, 2'b00, 0, 0, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 2'b01, i, 0, 1'b0, 0);
            if (i == 15) check("fill_done_rise", 64'(done), 64'd1);
            if (i == 14) check("fill_not_done", 64'(done), 64'd0);
        end
        check("fill_count", 64'(count), 64'd16);
        check("fill_dropped", 64'(dropped), 64'd0);
        for (int i = 0; i < 16; i++) read_tag(i, i, "fill_read");

        // Both channels valid: only ch0 is stored, ch1 is counted as dropped.
        applyStimulus(1'b1, 2'b00, 0, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b11, i, i + 10, 1'b0, 0);
        check("arb_count", 64'(count), 64'd4);
        check("arb_dropped", 64'(dropped), 64'd4);
        applyStimulus(1'b0, 2'b00, 0, 0, 1'b1, 3);
        check("arb_rd_ch", 64'(rd_ch), 64'd0);

        // Trigger on tag 7 with three post entries, no wrap.
        configure(1'b1, 0, 7, 3);
        applyStimulus(1'b1, 2'b00, 0, 0, 1'b0, 0);
        for (int i = 0; i <= 30; i++) applyStimulus(1'b0, 2'b01, i, 0, 1'b0, 0);
        check("trig_count", 64'(count), 64'd11);
        check("trig_done", 64'(done), 64'd1);
        read_tag(0, 0, "trig_first");
        read_tag(10, 10, "trig_last");

        // Trigger late enough that the buffer wraps.
        configure(1'b1, 0, 29, 3);
        applyStimulus(1'b1, 2'b00, 0, 0, 1'b0, 0);
        for (int i = 0; i <= 34; i++) applyStimulus(1'b0, 2'b01, i % 32, 0, 1'b0, 0);
        check("wrap_count", 64'(count), 64'd16);
        read_tag(0, 17, "wrap_oldest");
        read_tag(15, 0, "wrap_newest");

        // post_count 0: done right after the trigger entry.
        configure(1'b1, 0, 4, 0);
        applyStimulus(1'b1, 2'b00, 0, 0, 1'b0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'b01, i, 0, 1'b0, 0);
        check("post0_done", 64'(done), 64'd1);
        applyStimulus(1'b0, 2'b01, 20, 0, 1'b0, 0);
        check("post0_count", 64'(count), 64'd5);
        read_tag(4, 4, "post0_last");

        // arm during POST with an event present.
        configure(1'b1, 0, 2, 5);
        applyStimulus(1'b1, 2'b00, 0, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b01, i, 0, 1'b0, 0);
        applyStimulus(1'b1, 2'b11, 9, 9, 1'b0, 0);
        check("rearm_count", 64'(count), 64'd0);
        check("rearm_busy", 64'(busy), 64'd1);
        check("rearm_dropped", 64'(dropped), 64'd0);

        // Reset mid-capture.
        configure(1'b0, 0, 0, 0);
        applyStimulus(1'b1, 2'b00, 0, 0, 1'b0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'b01, i, 0, 1'b0, 0);
        do_reset();
        check("rst_count", 64'(count), 64'd0);
        applyStimulus(1'b0, 2'b00, 0, 0, 1'b1, 0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                configure(1'($urandom), int'($urandom_range(1)), int'($urandom_range(7)),
                          int'($urandom_range(15)));
                applyStimulus(($urandom_range(39) == 0), 2'($urandom), int'($urandom_range(7)),
                              int'($urandom_range(7)), 1'($urandom), int'($urandom_range(15)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
